// File: rtl/poly_tone_mixer.sv
// poly_tone_mixer
//   N-voice square-wave synthesiser and sequential mixer. Each frame starts
//   when the codec FIFO has room (allowed seen in IDLE), walks every voice
//   through a single adder (one voice per cycle), updates the per-voice
//   pitch counter and attack/release envelope, then presents one saturated
//   two's-complement sample with a one-cycle write strobe.
//
// Ports
//   clock         system clock
//   resetn        asynchronous active-low reset
//   key_on        per-voice gate, bit i = voice i held
//   half_period   voice i half-period in frames at [i*DIV_W +: DIV_W], 0 = mute
//   allowed       codec FIFO can accept a sample (sampled in IDLE only)
//   sound         mixed, saturated sample, held between frames
//   write         one-cycle strobe, sound is valid while high
//   active_count  number of voices whose envelope is nonzero after the frame
//
// state | meaning
// IDLE  | waiting for allowed; latches key_on and clears the accumulator
// ACCUM | processes voice v_q, one voice per cycle
// OUT   | write strobe high with the new sample on sound
module poly_tone_mixer #(
  parameter int NUM_VOICES   = 12,
  parameter int DIV_W        = 19,
  parameter int ENV_W        = 24,
  parameter int ENV_MAX      = 4194304,
  parameter int ATTACK_STEP  = 65536,
  parameter int RELEASE_STEP = 16384,
  parameter int SAMPLE_W     = 32
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [NUM_VOICES-1:0]             key_on,
  input  logic [NUM_VOICES*DIV_W-1:0]       half_period,
  input  logic                              allowed,
  output logic [SAMPLE_W-1:0]               sound,
  output logic                              write,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count
);

  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  localparam logic [ENV_W:0]   ENV_MAX_X = (ENV_W+1)'(ENV_MAX);
  localparam logic [ENV_W:0]   ATTACK_X  = (ENV_W+1)'(ATTACK_STEP);
  localparam logic [ENV_W-1:0] RELEASE_X = ENV_W'(RELEASE_STEP);
  localparam logic [VW-1:0]    LAST_V    = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                    state_q;
  logic [VW-1:0]             v_q;
  logic [NUM_VOICES-1:0]     key_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [ENV_W-1:0]          env_q   [NUM_VOICES];
  logic [DIV_W-1:0]          count_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]     phase_q;
  logic [SAMPLE_W-1:0]       sound_q;
  logic                      write_q;
  logic [CNT_W-1:0]          active_q;

  logic [ENV_W-1:0]          env_cur;
  logic [DIV_W-1:0]          count_cur;
  logic [DIV_W-1:0]          hp_cur;
  logic                      phase_cur;
  logic                      key_cur;
  logic [ENV_W:0]            env_sum;
  logic [ENV_W-1:0]          env_d;
  logic [DIV_W-1:0]          count_d;
  logic                      phase_d;
  logic signed [ACC_W-1:0]   mag;
  logic signed [ACC_W-1:0]   contrib;
  logic signed [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]          cnt_d;
  logic [SAMPLE_W-1:0]       sound_d;

  // Datapath for the voice currently selected by v_q.
  always_comb begin
    env_cur   = env_q[v_q];
    count_cur = count_q[v_q];
    phase_cur = phase_q[v_q];
    key_cur   = key_q[v_q];
    hp_cur    = half_period[v_q*DIV_W +: DIV_W];

    // Contribution uses the envelope and phase from before this frame's update.
    mag     = ACC_W'(env_cur);
    contrib = '0;
    if (hp_cur != '0) contrib = phase_cur ? -mag : mag;
    acc_d = acc_q + contrib;

    // One extra bit on the attack sum so the ceiling clamp cannot wrap.
    env_sum = {1'b0, env_cur} + ATTACK_X;
    env_d   = '0;
    if (key_cur) env_d = (env_sum > ENV_MAX_X) ? ENV_MAX_X[ENV_W-1:0] : env_sum[ENV_W-1:0];
    else if (env_cur > RELEASE_X) env_d = env_cur - RELEASE_X;

    // >= rather than == so a pitch lowered mid-tone toggles next frame.
    count_d = count_cur;
    phase_d = phase_cur;
    if (hp_cur != '0) begin
      if (count_cur >= hp_cur - 1'b1) begin
        count_d = '0;
        phase_d = ~phase_cur;
      end else begin
        count_d = count_cur + 1'b1;
      end
    end
    // A fully released voice restarts at phase 0 on its next strike.
    if (!key_cur && env_d == '0) begin
      count_d = '0;
      phase_d = 1'b0;
    end

    cnt_d = cnt_q + CNT_W'(env_d != '0);

    if (acc_d > SAT_MAX)      sound_d = SAT_MAX[SAMPLE_W-1:0];
    else if (acc_d < SAT_MIN) sound_d = SAT_MIN[SAMPLE_W-1:0];
    else                      sound_d = acc_d[SAMPLE_W-1:0];
  end

  // The sample and count are registered on the last ACCUM edge so they are
  // already valid during the OUT cycle, coincident with the write strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      v_q      <= '0;
      key_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= '0;
      sound_q  <= '0;
      write_q  <= 1'b0;
      active_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        env_q[i]   <= '0;
        count_q[i] <= '0;
      end
    end else begin
      write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (allowed) begin
            key_q   <= key_on;
            acc_q   <= '0;
            cnt_q   <= '0;
            v_q     <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          env_q[v_q]   <= env_d;
          count_q[v_q] <= count_d;
          phase_q[v_q] <= phase_d;
          acc_q        <= acc_d;
          cnt_q        <= cnt_d;
          if (v_q == LAST_V) begin
            sound_q  <= sound_d;
            active_q <= cnt_d;
            write_q  <= 1'b1;
            state_q  <= OUT;
          end else begin
            v_q <= v_q + 1'b1;
          end
        end
        OUT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sound        = sound_q;
  assign write        = write_q;
  assign active_count = active_q;

endmodule

// File: doc/poly_tone_mixer.md
Name: poly_tone_mixer

Overview:
- Parametrised N-voice square-wave synthesiser and mixer; successor to the fixed 12-key tone generator bank.
- Sits between the key/switch decoder and the Audio_Controller.
- Produces one signed, saturated sample per frame when the codec FIFO accepts data.
- Adds per-voice attack/release envelopes, runtime-programmable pitch, and a sequential one-adder mixer.

Parameters:
- NUM_VOICES, 12, number of voices.
- DIV_W, 19, width of each half-period field.
- ENV_W, 24, envelope amplitude width (unsigned).
- ENV_MAX, 4194304, envelope ceiling.
- ATTACK_STEP, 65536, envelope increment per frame while key held.
- RELEASE_STEP, 16384, envelope decrement per frame after key released.
- SAMPLE_W, 32, output sample width (two's complement).

Ports:
- clock  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous active-low reset.
- key_on  in  NUM_VOICES  per-voice gate; bit i = voice i held.
- half_period  in  NUM_VOICES*DIV_W  voice i pitch at bits [i*DIV_W +: DIV_W]; unit = frames.
- allowed  in  1  audio_out_allowed from Audio_Controller.
- sound  out  SAMPLE_W  mixed sample, held between frames.
- write  out  1  one-cycle strobe to write_audio_out.
- active_count  out  $clog2(NUM_VOICES+1)  number of voices with nonzero envelope.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports are named clock and resetn.
- Reset values:
  - sound=0, write=0, active_count=0, state=IDLE.
  - Every voice: env=0, phase=0, count=0, accumulator=0.
- FSM states IDLE, ACCUM, OUT:
  - IDLE: if allowed=1, latch key_on into key_r, clear accumulator, voice index v=0, go to ACCUM. Otherwise stay.
  - ACCUM: one voice per cycle, v = 0..NUM_VOICES-1. After v=NUM_VOICES-1, go to OUT.
  - OUT: sound <= saturated accumulator; write=1 for this cycle only; active_count updated; go to IDLE.
- Latency: write asserts exactly NUM_VOICES+1 cycles after the IDLE cycle that sampled allowed=1. Minimum frame period is NUM_VOICES+2 cycles.
- allowed is ignored outside IDLE. A frame, once started, always completes.
- Voice v, processed in its ACCUM cycle:
  - Contribution uses the pre-update env/phase: +env if phase=0, -env if phase=1; sign-extended to the accumulator width.
  - Accumulator width = SAMPLE_W + $clog2(NUM_VOICES) + 1.
  - Pitch update, if half_period_v != 0: when count >= half_period_v - 1, set count <= 0 and toggle phase; otherwise count <= count + 1.
  - If half_period_v = 0: contribution forced to 0; count and phase held.
  - The >= compare makes a mid-tone pitch decrease toggle at the next frame rather than wrapping.
  - Envelope, if key_r[v]=1: env <= min(env + ATTACK_STEP, ENV_MAX). Computed one bit wider; no wrap.
  - Envelope, if key_r[v]=0: env <= (env > RELEASE_STEP) ? env - RELEASE_STEP : 0.
  - When env reaches 0 with the key released, reset phase and count to 0 so re-strike starts at phase 0.
- Square wave period = 2*half_period frames.
- Saturation in OUT:
  - acc > 2^(SAMPLE_W-1)-1 clamps to max positive.
  - acc < -2^(SAMPLE_W-1) clamps to min negative.
  - Otherwise truncate to SAMPLE_W.
- active_count = popcount(env != 0) over the post-update envelopes of the frame.
- Key changes mid-frame: take effect next frame.
- Reset asserted mid-frame: immediate abort, no write, all state returns to reset values.

Test Plan:
- Reset then idle:
  - Stimulus: hold resetn=0, then release with allowed=0 for 100 cycles.
  - Required: sound=0, write never asserts, active_count=0.
- Single voice attack (defaults):
  - Stimulus: key_on=1, half_period[0]=92, allowed=1 continuously.
  - Required: write every 14 cycles, first strobe 13 cycles after the start cycle.
  - Required: sound magnitude 0, 65536, 131072, ..., plateau 4194304 from frame 65.
  - Required: sign flips every 92 frames.
- Release tail:
  - Stimulus: after plateau, drop key_on.
  - Required: |sound| decreases by 16384 per frame; reaches 0 after 256 frames; then active_count=0 and phase=0.
  - Required: re-strike produces a positive first sample.
- Saturation:
  - Stimulus: NUM_VOICES=4, SAMPLE_W=24, ATTACK_STEP=ENV_MAX; all keys on, all half_period=50.
  - Required: second frame outputs sound=8388607; after 50 frames sound=-8388608.
- Mute and backpressure:
  - Stimulus: half_period[3]=0 with key_on[3]=1; allowed toggled so it is high only mid-ACCUM.
  - Required: voice 3 contributes 0 but is counted in active_count.
  - Required: no new frame starts until allowed=1 is seen in IDLE.
- Reset mid-frame:
  - Stimulus: pulse resetn low at ACCUM v=5.
  - Required: write is not asserted, sound=0, next frame starts from env=0.
